// File: rtl/vex_wb_collect_pkg.sv
// Shared types and constants for the vector writeback collector.
//   VEX_XLEN / VEX_LANES : default element width and lane count
//   FFLAGS_W             : width of an FP exception flag vector
//   vex_wb_entry_t       : one buffered writeback row
package vex_wb_collect_pkg;

    localparam int unsigned VEX_XLEN  = 32;
    localparam int unsigned VEX_LANES = 8;
    localparam int unsigned FFLAGS_W  = 5;
    localparam int unsigned VEX_ROW_W = VEX_LANES * VEX_XLEN;

    typedef struct packed {
        logic [4:0]           dst;
        logic                 end_uop;
        logic [VEX_LANES-1:0] elem_en;
        logic [VEX_ROW_W-1:0] data;
        logic [FFLAGS_W-1:0]  flags;
    } vex_wb_entry_t;

    localparam int unsigned VEX_ENTRY_W = $bits(vex_wb_entry_t);

endpackage

// File: rtl/vex_wb_collect_if.sv
// VRF write port bundle.
//   master : collector side (drives valid/addr/data/elem_en, receives ready)
//   slave  : register file side
interface vex_wb_collect_if #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned VECTOR_LANES = 8
);
    logic                         vrf_wr_valid;
    logic                         vrf_wr_ready;
    logic [4:0]                   vrf_wr_addr;
    logic [VECTOR_LANES*XLEN-1:0] vrf_wr_data;
    logic [VECTOR_LANES-1:0]      vrf_wr_elem_en;

    modport master (
        output vrf_wr_valid,
        output vrf_wr_addr,
        output vrf_wr_data,
        output vrf_wr_elem_en,
        input  vrf_wr_ready
    );

    modport slave (
        input  vrf_wr_valid,
        input  vrf_wr_addr,
        input  vrf_wr_data,
        input  vrf_wr_elem_en,
        output vrf_wr_ready
    );
endinterface

// File: rtl/vex_wb_fifo.sv
// Generic synchronous FIFO, head visible without a pop.
//   push_i/din_i   : write request (ignored when full unless popping)
//   pop_i          : read request (ignored when empty)
//   head_o         : oldest entry
//   count_next_o   : occupancy after this cycle's push/pop
//   full_o/empty_o : occupancy flags
module vex_wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_next_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o       = (count_q == CNT_W'(DEPTH));
    assign empty_o      = (count_q == '0);
    assign head_o       = mem_q[rd_ptr_q];
    assign count_next_o = count_d;

    // A push into a full FIFO is only accepted if the head leaves in the same cycle.
    always_comb begin
        do_push  = push_i & (~full_o | pop_i);
        do_pop   = pop_i & ~empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/vex_wb_collect.sv
// Vector writeback collector: gathers one row of lane results per cycle,
// buffers rows in a FIFO and drains them to the VRF write port.
//   lane_wr_en_i/lane_wr_data_i/lane_fflags_i : per-lane results
//   wb_dst_i/wb_end_i : row destination and end-of-instruction marker
//   stall_o           : issue back-pressure
//   vrf               : VRF write port (master side)
//   instr_done_o/fflags_o : completion pulse and accumulated FP flags
//   overflow_err_o    : sticky, a row was dropped on a full FIFO
// Optional: define VEX_WB_BYPASS_EN to forward a row straight to the VRF
// port when the FIFO is empty.
module vex_wb_collect
    import vex_wb_collect_pkg::*;
#(
    parameter int unsigned XLEN          = VEX_XLEN,
    parameter int unsigned VECTOR_LANES  = VEX_LANES,
    parameter int unsigned WB_FIFO_DEPTH = 8,
    parameter int unsigned STALL_SLACK   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [VECTOR_LANES-1:0]      lane_wr_en_i,
    input  logic [VECTOR_LANES*XLEN-1:0] lane_wr_data_i,
    input  logic [VECTOR_LANES*5-1:0]    lane_fflags_i,
    input  logic [4:0]                   wb_dst_i,
    input  logic                         wb_end_i,
    output logic                         stall_o,
    vex_wb_collect_if.master             vrf,
    output logic                         instr_done_o,
    output logic [4:0]                   fflags_o,
    output logic                         overflow_err_o
);

    localparam int unsigned CNT_W = $clog2(WB_FIFO_DEPTH) + 1;

    vex_wb_entry_t       row_c;
    vex_wb_entry_t       head;
    vex_wb_entry_t       out_c;
    logic                row_push_c;
    logic                out_valid_c;
    logic                fifo_push_c;
    logic                fifo_pop_c;
    logic                hs_c;
    logic                drop_c;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count_next;

    logic                stall_q, stall_d;
    logic                done_q, done_d;
    logic [FFLAGS_W-1:0] fflags_q, fflags_d;
    logic [FFLAGS_W-1:0] acc_q, acc_d;
    logic                ovf_q, ovf_d;

    // Row assembly: disabled lanes contribute neither data nor flags.
    always_comb begin
        row_c         = '0;
        row_c.dst     = wb_dst_i;
        row_c.end_uop = wb_end_i;
        row_c.elem_en = lane_wr_en_i;
        for (int k = 0; k < int'(VECTOR_LANES); k++) begin
            if (lane_wr_en_i[k]) begin
                row_c.data[k*XLEN +: XLEN] = lane_wr_data_i[k*XLEN +: XLEN];
                row_c.flags = row_c.flags | lane_fflags_i[k*FFLAGS_W +: FFLAGS_W];
            end
        end
    end

    assign row_push_c = |lane_wr_en_i;

`ifdef VEX_WB_BYPASS_EN
    // Empty FIFO: the incoming row is presented immediately and skips the
    // FIFO when the VRF takes it in the same cycle.
    logic bypass_c;
    assign bypass_c    = row_push_c & fifo_empty;
    assign out_c       = bypass_c ? row_c : head;
    assign out_valid_c = ~fifo_empty | row_push_c;
    assign fifo_push_c = row_push_c & ~(bypass_c & vrf.vrf_wr_ready);
    assign fifo_pop_c  = ~fifo_empty & vrf.vrf_wr_ready;
`else
    assign out_c       = head;
    assign out_valid_c = ~fifo_empty;
    assign fifo_push_c = row_push_c;
    assign fifo_pop_c  = out_valid_c & vrf.vrf_wr_ready;
`endif

    assign hs_c   = out_valid_c & vrf.vrf_wr_ready;
    assign drop_c = fifo_push_c & fifo_full & ~fifo_pop_c;

    vex_wb_fifo #(
        .WIDTH (VEX_ENTRY_W),
        .DEPTH (WB_FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (fifo_push_c),
        .din_i        (row_c),
        .pop_i        (fifo_pop_c),
        .head_o       (head),
        .count_next_o (fifo_count_next),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    // Zero the payload when idle so the port never shows stale storage.
    assign vrf.vrf_wr_valid   = out_valid_c;
    assign vrf.vrf_wr_addr    = out_valid_c ? out_c.dst : '0;
    assign vrf.vrf_wr_data    = out_valid_c ? out_c.data : '0;
    assign vrf.vrf_wr_elem_en = out_valid_c ? out_c.elem_en : '0;

    // Flag accumulation, completion pulse, stall and overflow tracking.
    always_comb begin
        acc_d    = acc_q;
        done_d   = 1'b0;
        fflags_d = fflags_q;
        ovf_d    = ovf_q | drop_c;
        stall_d  = (CNT_W'(WB_FIFO_DEPTH) - fifo_count_next) <= CNT_W'(STALL_SLACK);
        if (hs_c) begin
            if (out_c.end_uop) begin
                done_d   = 1'b1;
                fflags_d = acc_q | out_c.flags;
                acc_d    = '0;
            end else begin
                acc_d    = acc_q | out_c.flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= 1'b0;
            done_q   <= 1'b0;
            fflags_q <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            stall_q  <= stall_d;
            done_q   <= done_d;
            fflags_q <= fflags_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
        end
    end

    assign stall_o        = stall_q;
    assign instr_done_o   = done_q;
    assign fflags_o       = fflags_q;
    assign overflow_err_o = ovf_q;

endmodule

// File: tb/tb_vex_wb_collect.sv
// Scoreboard bench for vex_wb_collect (default build, no bypass).
module tb_vex_wb_collect;
    import vex_wb_collect_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned LANES = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned SLACK = 4;

    typedef struct {
        logic [4:0]            addr;
        logic [LANES-1:0]      en;
        logic [LANES*XLEN-1:0] data;
    } exp_row_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [LANES-1:0]      lane_wr_en;
    logic [LANES*XLEN-1:0] lane_wr_data;
    logic [LANES*5-1:0]    lane_fflags;
    logic [4:0]            wb_dst;
    logic                  wb_end;
    logic                  stall;
    logic                  instr_done;
    logic [4:0]            fflags;
    logic                  overflow_err;

    int n_tests = 0;
    int n_fail  = 0;

    exp_row_t   exp_row_q[$];
    logic [4:0] exp_done_q[$];
    logic [4:0] acc_m = '0;
    exp_row_t   mon_row;
    logic [4:0] mon_flags;

    always #5 clk = ~clk;

    vex_wb_collect_if #(.XLEN(XLEN), .VECTOR_LANES(LANES)) vrf_if ();

    vex_wb_collect #(
        .XLEN          (XLEN),
        .VECTOR_LANES  (LANES),
        .WB_FIFO_DEPTH (DEPTH),
        .STALL_SLACK   (SLACK)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .lane_wr_en_i   (lane_wr_en),
        .lane_wr_data_i (lane_wr_data),
        .lane_fflags_i  (lane_fflags),
        .wb_dst_i       (wb_dst),
        .wb_end_i       (wb_end),
        .stall_o        (stall),
        .vrf            (vrf_if),
        .instr_done_o   (instr_done),
        .fflags_o       (fflags),
        .overflow_err_o (overflow_err)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one row for one cycle and record what the VRF should see.
    task automatic push_row(input logic [LANES-1:0] en, input logic [LANES*XLEN-1:0] data,
                            input logic [LANES*5-1:0] fl, input logic [4:0] dst,
                            input logic endf, input bit keep);
        exp_row_t   r;
        logic [4:0] f;
        r.addr = dst;
        r.en   = en;
        r.data = '0;
        f      = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            if (en[k]) begin
                r.data[k*XLEN +: XLEN] = data[k*XLEN +: XLEN];
                f = f | fl[k*5 +: 5];
            end
        end
        if (keep) begin
            exp_row_q.push_back(r);
            acc_m = acc_m | f;
            if (endf) begin
                exp_done_q.push_back(acc_m);
                acc_m = '0;
            end
        end
        lane_wr_en   = en;
        lane_wr_data = data;
        lane_fflags  = fl;
        wb_dst       = dst;
        wb_end       = endf;
        tick();
        lane_wr_en   = '0;
        lane_wr_data = '0;
        lane_fflags  = '0;
        wb_end       = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int c = 0;
        while ((exp_row_q.size() != 0 || exp_done_q.size() != 0) && c < max_cycles) begin
            tick();
            c++;
        end
        chk("drain_timeout_left", 256'(exp_row_q.size() + exp_done_q.size()), 256'd0);
    endtask

    // Monitor: every accepted VRF write and every done pulse is matched in order.
    always @(negedge clk) begin
        if (vrf_if.vrf_wr_valid === 1'b1 && vrf_if.vrf_wr_ready === 1'b1) begin
            if (exp_row_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL row_unexpected: got addr %0h expected no row", vrf_if.vrf_wr_addr);
            end else begin
                mon_row = exp_row_q.pop_front();
                chk("row_addr", 256'(vrf_if.vrf_wr_addr), 256'(mon_row.addr));
                chk("row_elem_en", 256'(vrf_if.vrf_wr_elem_en), 256'(mon_row.en));
                chk("row_data", vrf_if.vrf_wr_data, mon_row.data);
            end
        end
        if (instr_done === 1'b1) begin
            if (exp_done_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_unexpected: got done with flags %0h expected no done", fflags);
            end else begin
                mon_flags = exp_done_q.pop_front();
                chk("done_fflags", 256'(fflags), 256'(mon_flags));
            end
        end
    end

    initial begin
        logic [LANES*XLEN-1:0] d;
        rst                 = 1'b1;
        lane_wr_en          = '0;
        lane_wr_data        = '0;
        lane_fflags         = '0;
        wb_dst              = '0;
        wb_end              = 1'b0;
        vrf_if.vrf_wr_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_stall", 256'(stall), 256'd0);
        chk("rst_valid", 256'(vrf_if.vrf_wr_valid), 256'd0);
        chk("rst_addr", 256'(vrf_if.vrf_wr_addr), 256'd0);
        chk("rst_data", vrf_if.vrf_wr_data, 256'd0);
        chk("rst_elem_en", 256'(vrf_if.vrf_wr_elem_en), 256'd0);
        chk("rst_done", 256'(instr_done), 256'd0);
        chk("rst_fflags", 256'(fflags), 256'd0);
        chk("rst_overflow", 256'(overflow_err), 256'd0);

        // Single full row, one-cycle latency, done on the following cycle
        vrf_if.vrf_wr_ready = 1'b1;
        for (int k = 0; k < int'(LANES); k++) d[k*XLEN +: XLEN] = 32'(k + 1);
        push_row(8'hFF, d, '0, 5'd3, 1'b1, 1'b1);
        @(negedge clk);
        chk("single_valid", 256'(vrf_if.vrf_wr_valid), 256'd1);
        chk("single_addr", 256'(vrf_if.vrf_wr_addr), 256'd3);
        chk("single_elem_en", 256'(vrf_if.vrf_wr_elem_en), 256'hFF);
        chk("single_data", vrf_if.vrf_wr_data,
            256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
        @(negedge clk);
        chk("single_done", 256'(instr_done), 256'd1);
        chk("single_fflags", 256'(fflags), 256'd0);
        tick();

        // Reduction: only lane 0 written, other lanes zeroed
        for (int k = 0; k < int'(LANES); k++) d[k*XLEN +: XLEN] = 32'hDEAD_0000 + 32'(k);
        d[31:0] = 32'h1234;
        push_row(8'h01, d, '0, 5'd7, 1'b1, 1'b1);
        @(negedge clk);
        chk("red_elem_en", 256'(vrf_if.vrf_wr_elem_en), 256'h01);
        chk("red_data", vrf_if.vrf_wr_data, 256'h1234);
        wait_drain(20);
        tick();

        // Back-pressure: stall once four rows are held, no overflow at eight
        vrf_if.vrf_wr_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            for (int k = 0; k < int'(LANES); k++) d[k*XLEN +: XLEN] = 32'(i * 16 + k);
            push_row(8'hFF, d, '0, 5'(i), 1'b1, 1'b1);
            @(negedge clk);
            chk($sformatf("bp_stall_after_push%0d", i), 256'(stall), 256'(i >= 4));
        end
        chk("bp_no_overflow", 256'(overflow_err), 256'd0);
        tick();
        vrf_if.vrf_wr_ready = 1'b1;
        wait_drain(40);
        @(negedge clk);
        chk("bp_stall_released", 256'(stall), 256'd0);
        tick();

        // Flags: three-uop instruction, disabled-lane flags ignored
        push_row(8'h01, 256'h5, (40'(5'b01000) << 25) | 40'(5'b00001), 5'd9, 1'b0, 1'b1);
        push_row(8'h08, 256'h6 << 96, 40'(5'b00100) << 15, 5'd9, 1'b0, 1'b1);
        push_row(8'h80, 256'h7 << 224, 40'(5'b10000) << 35, 5'd9, 1'b1, 1'b1);
        wait_drain(20);
        tick();
        tick();
        @(negedge clk);
        chk("flags_hold", 256'(fflags), 256'b10101);
        chk("flags_no_pulse", 256'(instr_done), 256'd0);
        push_row(8'h03, 256'hAB, '0, 5'd10, 1'b1, 1'b1);
        wait_drain(20);
        tick();
        @(negedge clk);
        chk("flags_cleared", 256'(fflags), 256'd0);
        tick();

        // Overflow: ninth row dropped, sticky error
        vrf_if.vrf_wr_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            push_row(8'h0F, 256'(i) << 32, '0, 5'(10 + i), 1'b1, (i <= 8));
        end
        @(negedge clk);
        chk("ovf_set", 256'(overflow_err), 256'd1);
        tick();
        tick();
        @(negedge clk);
        chk("ovf_sticky_idle", 256'(overflow_err), 256'd1);
        vrf_if.vrf_wr_ready = 1'b1;
        wait_drain(40);
        tick();
        tick();
        @(negedge clk);
        chk("ovf_sticky_drained", 256'(overflow_err), 256'd1);
        chk("ovf_empty_after", 256'(vrf_if.vrf_wr_valid), 256'd0);
        tick();

        // Reset mid-drain: buffered rows vanish, no done pulse
        vrf_if.vrf_wr_ready = 1'b0;
        for (int i = 1; i <= 3; i++) push_row(8'hFF, 256'(i), '0, 5'(20 + i), 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_row_q.delete();
        exp_done_q.delete();
        acc_m = '0;
        @(negedge clk);
        chk("mrst_valid", 256'(vrf_if.vrf_wr_valid), 256'd0);
        chk("mrst_stall", 256'(stall), 256'd0);
        chk("mrst_overflow", 256'(overflow_err), 256'd0);
        chk("mrst_done", 256'(instr_done), 256'd0);
        vrf_if.vrf_wr_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("mrst_still_idle", 256'(vrf_if.vrf_wr_valid), 256'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
